// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/add/shift operations
// and a multi-cycle shift-add unsigned multiplier.
module alu_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_val_a,
  input  logic [DATA_WIDTH-1:0] i_val_b,
  input  logic                  i_carry,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry,
  output logic                  o_zero,
  output logic                  o_neg,
  output logic                  o_ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t          state_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [W-1:0]    result_reg;
  logic            carry_reg;
  logic            zero_reg;
  logic            neg_reg;
  logic            ovf_reg;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right
  logic [2*W-1:0]  mcand_reg;
  logic [2*W-1:0]  acc_reg;
  logic [W-1:0]    mplier_reg;
  logic [CW-1:0]   count_reg;

  logic [W-1:0]    b_eff;
  logic [W:0]      sum_full;
  logic [W-1:0]    res_next;
  logic            carry_next;
  logic            ovf_next;
  logic [2*W-1:0]  addend;
  logic [2*W-1:0]  acc_next;

  // Single-cycle ALU result and flags; SUB is A + ~B + cin at full width
  always_comb begin
    b_eff      = (i_op == OP_SUB) ? ~i_val_b : i_val_b;
    sum_full   = {1'b0, i_val_a} + {1'b0, b_eff} + {{W{1'b0}}, i_carry};
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB: begin
        res_next   = sum_full[W-1:0];
        carry_next = sum_full[W];
        ovf_next   = (i_val_a[W-1] == b_eff[W-1]) && (sum_full[W-1] != i_val_a[W-1]);
      end
      OP_AND: res_next = i_val_a & i_val_b;
      OP_OR:  res_next = i_val_a | i_val_b;
      OP_XOR: res_next = i_val_a ^ i_val_b;
      OP_SHL: begin
        res_next   = {i_val_a[W-2:0], i_carry};
        carry_next = i_val_a[W-1];
      end
      OP_SHR: begin
        res_next   = {i_carry, i_val_a[W-1:1]};
        carry_next = i_val_a[0];
      end
      default: ;  // MUL result comes from the sequential datapath
    endcase
  end

  // Partial product: multiplicand gated by the current multiplier LSB
  genvar gi;
  generate
    for (gi = 0; gi < 2*W; gi++) begin : g_pp
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_next = acc_reg + addend;

  // Control FSM with registered result, flags and handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= ST_IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            if (i_op == OP_MUL) begin
              state_reg  <= ST_MUL;
              busy_reg   <= 1'b1;
              mcand_reg  <= {{W{1'b0}}, i_val_a};
              mplier_reg <= i_val_b;
              acc_reg    <= '0;
              count_reg  <= '0;
            end else begin
              result_reg <= res_next;
              carry_reg  <= carry_next;
              zero_reg   <= (res_next == '0);
              neg_reg    <= res_next[W-1];
              ovf_reg    <= ovf_next;
              done_reg   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + CW'(1);
          // Last step: publish the full product straight from the adder
          if (count_reg == CW'(W - 1)) begin
            result_reg <= acc_next[W-1:0];
            carry_reg  <= |acc_next[2*W-1:W];
            zero_reg   <= (acc_next[W-1:0] == '0);
            neg_reg    <= acc_next[W-1];
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_busy   = busy_reg;
  assign o_done   = done_reg;
  assign o_result = result_reg;
  assign o_carry  = carry_reg;
  assign o_zero   = zero_reg;
  assign o_neg    = neg_reg;
  assign o_ovf    = ovf_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; stimulus pushes expected
// results from an arithmetic reference model, a monitor pops on o_done.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, carry, zero, neg, ovf;
  logic [W-1:0] result;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_val_a(a), .i_val_b(b), .i_carry(cin),
    .o_busy(busy), .o_done(done), .o_result(result),
    .o_carry(carry), .o_zero(zero), .o_neg(neg), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic c, z, n, v;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   end_req = 1'b0;
  bit   end_done = 1'b0;
  logic [W+3:0] last_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic on the operation definitions
  function automatic exp_t model(input int opv, input int av, input int bv, input int cv);
    exp_t   e;
    longint mask, half, x, s, sa, sx, ss, r;
    mask = (longint'(1) << W) - 1;
    half = longint'(1) << (W - 1);
    e.c = 1'b0; e.v = 1'b0; r = 0;
    case (opv)
      0, 1: begin
        x  = (opv == 1) ? (mask - bv) : bv;
        s  = av + x + cv;
        r  = s & mask;
        e.c = (s > mask);
        sa = (av >= half) ? av - 2*half : av;
        sx = (x  >= half) ? x  - 2*half : x;
        ss = sa + sx + cv;
        e.v = (ss >= half) || (ss < -half);
      end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: begin r = (av * 2 + cv) & mask; e.c = (av >= half); end
      6: begin r = av / 2 + cv * half;    e.c = (av % 2 == 1); end
      default: begin
        s = longint'(av) * longint'(bv);
        r = s & mask;
        e.c = (s > mask);
      end
    endcase
    e.res = r[W-1:0];
    e.z = (r == 0);
    e.n = (r >= half);
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, expv);
    end
  endtask

  // Monitor: reset state, busy window, result on o_done, hold otherwise
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {busy, done, result, carry, zero, neg, ovf}, 0);
      exp_q.delete();
      last_val = '0;
    end else begin
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_flags", {result, carry, zero, neg, ovf}, {e.res, e.c, e.z, e.n, e.v});
          chk("done_cycle", cyc, e.cyc);
          last_val = {e.res, e.c, e.z, e.n, e.v};
        end
      end else begin
        chk("hold", {result, carry, zero, neg, ovf}, last_val);
      end
    end
    if (end_req && !end_done) begin
      chk("drain_pending", exp_q.size(), 0);
      end_done = 1'b1;
    end
  end

  // Issue one operation; for MUL, spend the busy cycles driving stray starts
  task automatic issue(input logic [2:0] opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input int spur);
    exp_t e;
    e = model(int'(opv), int'(av), int'(bv), int'(cv));
    e.cyc = cyc + 1 + ((opv == 3'd7) ? W : 0);
    exp_q.push_back(e);
    if (opv == 3'd7) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + W;
    end
    start = 1'b1; op = opv; a = av; b = bv; cin = cv;
    @(posedge clk); #1;
    start = 1'b0;
    if (opv == 3'd7) begin
      for (int j = 0; j < W; j++) begin
        if (spur == 1 || (spur == 0 && $urandom_range(0, 3) == 0)) begin
          start = 1'b1;
          op  = (spur == 1) ? 3'd0 : 3'($urandom_range(0, 7));
          a   = W'($urandom);
          b   = W'($urandom);
          cin = 1'($urandom);
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 8'h7F, 8'h01, 1'b0, 2);   // ADD signed overflow
    issue(3'd1, 8'h05, 8'h05, 1'b1, 2);   // SUB to zero, no borrow
    issue(3'd6, 8'h01, 8'h00, 1'b1, 2);   // SHR back-to-back
    issue(3'd7, 8'h0F, 8'h11, 1'b0, 2);   // MUL 0xFF
    issue(3'd7, 8'h10, 8'h10, 1'b0, 2);   // MUL high half only
    issue(3'd7, 8'h03, 8'h05, 1'b0, 1);   // ADD starts while busy ignored

    // Reset in the 4th MUL cycle: aborted, no done
    start = 1'b1; op = 3'd7; a = 8'h0F; b = 8'h0F; cin = 1'b0;
    busy_lo = cyc + 1;
    busy_hi = cyc + W;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    busy_lo = 1;
    busy_hi = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(3'd0, 8'h01, 8'h01, 1'b0, 2);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    end_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand/result width in bits; legal values are 2..32.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_start, input, 1 bit: request to start an operation, sampled on each rising edge.
REQ-005 The block SHALL have port i_op, input, 3 bits: opcode, sampled with i_start.
REQ-006 The block SHALL have ports i_val_a and i_val_b, input, DATA_WIDTH bits each: operands A and B, sampled with i_start.
REQ-007 The block SHALL have port i_carry, input, 1 bit: carry-in or shift-in bit, sampled with i_start.
REQ-008 The block SHALL have port o_busy, output, 1 bit: high while a multi-cycle operation is executing.
REQ-009 The block SHALL have port o_done, output, 1 bit: one-cycle pulse marking that the result and flags have just updated.
REQ-010 The block SHALL have port o_result, output, DATA_WIDTH bits: the registered result.
REQ-011 The block SHALL have ports o_carry, o_zero, o_neg and o_ovf, output, 1 bit each: the registered carry, zero, negative and signed-overflow flags.

Function
REQ-012 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-013 ADD SHALL compute A + B + i_carry, with o_carry taken from bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum.
REQ-014 SUB SHALL compute A + ~B + i_carry, so i_carry=1 gives A-B and o_carry=1 means no borrow.
REQ-015 For ADD and SUB, o_ovf SHALL be set when the operand sign bits (A and B for ADD; A and ~B for SUB) match each other and differ from the result sign bit.
REQ-016 AND, OR and XOR SHALL be bitwise, and SHALL force o_carry=0 and o_ovf=0.
REQ-017 SHL SHALL compute {A[DATA_WIDTH-2:0], i_carry} with o_carry=A[DATA_WIDTH-1]; SHR SHALL compute {i_carry, A[DATA_WIDTH-1:1]} with o_carry=A[0]; both shifts SHALL force o_ovf=0.
REQ-018 MUL SHALL compute the unsigned product A*B, with o_result = low DATA_WIDTH bits, o_carry=1 iff the high DATA_WIDTH bits are nonzero, and o_ovf=0; i_carry is ignored.
REQ-019 For every opcode, o_zero SHALL equal (o_result==0) and o_neg SHALL equal o_result[DATA_WIDTH-1].
REQ-020 The FSM SHALL have states IDLE and MUL; i_start=1 sampled in IDLE accepts the operation.
REQ-021 A non-MUL operation SHALL complete with latency 1: on the accepting edge, outputs update, o_done goes high for one cycle, and the FSM stays in IDLE.
REQ-022 A MUL operation SHALL go from IDLE to MUL on the accepting edge and raise o_busy.
REQ-023 In MUL, the block SHALL run one shift-add step per cycle for DATA_WIDTH cycles, then update outputs, pulse o_done, drop o_busy and return to IDLE; total latency is DATA_WIDTH+1 edges.
REQ-024 o_result and all flags SHALL hold their values between completions and SHALL not change during MUL execution.
REQ-025 i_start SHALL be ignored while o_busy=1.
REQ-026 i_start in the cycle o_done is high, with the FSM in IDLE, SHALL be accepted, giving back-to-back operations.
REQ-027 An undefined DATA_WIDTH-dependent case is not permitted: all arithmetic SHALL be computed at DATA_WIDTH+1 bits (2*DATA_WIDTH bits for MUL) with no truncation before flag extraction.

Reset
REQ-028 While i_rst_n=0, the FSM SHALL be IDLE and o_busy, o_done, o_result, o_carry, o_neg and o_ovf SHALL all be 0; o_zero SHALL be 0 (no valid result yet).
REQ-029 Reset asserted mid-MUL SHALL abort the operation with no o_done pulse, and the first operation started after reset release SHALL execute normally.

Verification (DATA_WIDTH=8)
REQ-030 ADD A=0x7F, B=0x01, cin=0 -> result 0x80, carry 0, neg 1, ovf 1, zero 0, with o_done exactly 1 cycle after start.
REQ-031 SUB A=0x05, B=0x05, cin=1 -> result 0x00, carry 1, zero 1, ovf 0; back-to-back with SHR A=0x01, cin=1 -> result 0x80, carry 1, neg 1.
REQ-032 MUL 0x0F*0x11 -> result 0xFF, carry 0, with o_busy high for 8 cycles and o_done at edge 9; then MUL 0x10*0x10 -> result 0x00, carry 1, zero 1.
REQ-033 ADD start issued during MUL busy -> ignored; only the MUL result is delivered, and exactly one o_done pulse occurs.
REQ-034 i_rst_n pulsed low during the 4th MUL cycle -> all outputs 0 immediately with no o_done; after release, ADD 0x01+0x01 -> result 0x02.
